// File: rtl/chip8_fb_draw_ctrl.sv
// CHIP-8 display sequencer: runs CLS and DRW (XOR sprite) on the framebuffer general port.
// Define FB_DRAW_CLIP_EN to clip off-screen pixels instead of wrapping them.
module chip8_fb_draw_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [3:0]  cmd_n,
    input  logic [11:0] cmd_i,
    output logic        done,
    output logic        collision,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [5:0]  fb_addr_x,
    output logic [4:0]  fb_addr_y,
    output logic        fb_writedata,
    output logic        fb_WE,
    input  logic        fb_readdata
);

    typedef enum logic [2:0] {
        StIdle, StClr, StFetch, StFwait, StPrd, StPwr, StDone
    } state_t;

    state_t      state_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [11:0] i_q;
    logic [3:0]  row_q;
    logic [2:0]  bit_q;
    logic [7:0]  byte_q;
    logic [10:0] cnt_q;

    logic [5:0]  px;
    logic [4:0]  py;
    logic        clip;
    logic        sbit;

`ifdef FB_DRAW_CLIP_EN
    logic [6:0] px_full;
    logic [5:0] py_full;
    assign px_full = {1'b0, x_q} + {4'b0, bit_q};
    assign py_full = {1'b0, y_q} + {2'b0, row_q};
    assign px      = px_full[5:0];
    assign py      = py_full[4:0];
    assign clip    = px_full[6] | py_full[5];
`else
    assign px   = x_q + {3'b0, bit_q};
    assign py   = y_q + {1'b0, row_q};
    assign clip = 1'b0;
`endif

    assign sbit = byte_q[3'd7 - bit_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            row_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            cnt_q     <= '0;
            collision <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        n_q       <= cmd_n;
                        i_q       <= cmd_i;
                        row_q     <= '0;
                        bit_q     <= '0;
                        cnt_q     <= '0;
                        collision <= 1'b0;
                        if (cmd_op)              state_q <= StClr;
                        else if (cmd_n != 4'd0)  state_q <= StFetch;
                        else                     state_q <= StDone;
                    end
                end
                StClr: begin
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q == 11'h7ff) state_q <= StDone;
                end
                StFetch: state_q <= StFwait;
                StFwait: begin
                    byte_q  <= mem_data;
                    state_q <= StPrd;
                end
                StPrd: state_q <= StPwr;
                StPwr: begin
                    if (fb_readdata && sbit && !clip) collision <= 1'b1;
                    if (bit_q != 3'd7) begin
                        bit_q   <= bit_q + 3'd1;
                        state_q <= StPrd;
                    end else if (row_q != n_q - 4'd1) begin
                        row_q   <= row_q + 4'd1;
                        bit_q   <= '0;
                        state_q <= StFetch;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode from registered state; PWR write data must follow fb_readdata directly.
    always_comb begin
        cmd_ready    = (state_q == StIdle);
        done         = (state_q == StDone);
        mem_addr     = '0;
        mem_rd       = 1'b0;
        fb_addr_x    = '0;
        fb_addr_y    = '0;
        fb_writedata = 1'b0;
        fb_WE        = 1'b0;
        case (state_q)
            StClr: begin
                fb_addr_x = cnt_q[5:0];
                fb_addr_y = cnt_q[10:6];
                fb_WE     = 1'b1;
            end
            StFetch: begin
                mem_addr = i_q + {8'b0, row_q};
                mem_rd   = 1'b1;
            end
            StPrd: begin
                fb_addr_x = px;
                fb_addr_y = py;
            end
            StPwr: begin
                fb_addr_x    = px;
                fb_addr_y    = py;
                fb_writedata = fb_readdata ^ sbit;
                fb_WE        = sbit & ~clip;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_fb_draw_ctrl.sv
// Directed bench for chip8_fb_draw_ctrl with framebuffer and sprite-memory models.
module tb_chip8_fb_draw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_i;
    logic        done, collision;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic [5:0]  fb_addr_x;
    logic [4:0]  fb_addr_y;
    logic        fb_writedata, fb_WE;
    logic        fb_readdata = 1'b0;

    logic [7:0]  mem [0:4095];
    logic        fb  [0:2047];
    logic        fill_req = 1'b0;
    logic        clr_mode = 1'b0;
    int          we_cnt = 0, rd_cnt = 0, addr_bad = 0, we_base = 0;
    int          checks = 0, errors = 0;
    int          lat, we0, rd0, ones;

    chip8_fb_draw_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .done(done), .collision(collision), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .fb_addr_x(fb_addr_x), .fb_addr_y(fb_addr_y),
        .fb_writedata(fb_writedata), .fb_WE(fb_WE), .fb_readdata(fb_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem[mem_addr];
            rd_cnt   <= rd_cnt + 1;
        end
    end

    always @(posedge clk) begin
        fb_readdata <= fb[{fb_addr_y, fb_addr_x}];
        if (fill_req) begin
            for (int k = 0; k < 2048; k++) fb[k] <= 1'($urandom % 2);
        end else if (fb_WE) begin
            fb[{fb_addr_y, fb_addr_x}] <= fb_writedata;
        end
        if (fb_WE) begin
            if (clr_mode && ({fb_addr_y, fb_addr_x} != 11'(we_cnt - we_base)))
                addr_bad <= addr_bad + 1;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get8(input logic [4:0] y, input logic [5:0] x0);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = fb[{y, 6'(x0 + 6'(k))}];
        return r;
    endfunction

    // Starts at a negedge, ends at the negedge of the first cycle after accept.
    task automatic start_cmd(input logic op, input logic [5:0] x, input logic [4:0] y,
                             input logic [3:0] n, input logic [11:0] i);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_n = n; cmd_i = i;
        cmd_valid = 1'b1;
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int limit, output int l);
        l = start;
        while (!done && l < limit) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run(input logic op, input logic [5:0] x, input logic [4:0] y,
                       input logic [3:0] n, input logic [11:0] i, output int l);
        we0 = we_cnt; rd0 = rd_cnt;
        start_cmd(op, x, y, n, i);
        wait_done(1, 3000, l);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_coll"}, 32'(collision), 32'd0);
        check({tag, "_mem"}, {19'd0, mem_rd, mem_addr}, 32'd0);
        check({tag, "_fb"}, {18'd0, fb_WE, fb_writedata, fb_addr_y, fb_addr_x}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
        for (int k = 0; k < 2048; k++) fb[k] = 1'b0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_n = '0; cmd_i = '0;
        #12;
        check_reset_outputs("por");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // CLS after random fill
        fill_req = 1'b1; @(negedge clk); fill_req = 1'b0;
        we_base = we_cnt; clr_mode = 1'b1;
        run(1'b1, 6'd0, 5'd0, 4'd0, 12'h000, lat);
        check("cls_latency", 32'(lat), 32'd2049);
        check("cls_we_count", 32'(we_cnt - we0), 32'd2048);
        check("cls_addr_seq", 32'(addr_bad), 32'd0);
        @(negedge clk); clr_mode = 1'b0;
        ones = 0;
        for (int k = 0; k < 2048; k++) ones += int'(fb[k]);
        check("cls_all_zero", 32'(ones), 32'd0);

        // Single-row draw
        mem[12'h200] = 8'hFF;
        run(1'b0, 6'd0, 5'd0, 4'd1, 12'h200, lat);
        check("drw1_latency", 32'(lat), 32'd19);
        check("drw1_coll", 32'(collision), 32'd0);
        check("drw1_we", 32'(we_cnt - we0), 32'd8);
        check("drw1_rd", 32'(rd_cnt - rd0), 32'd1);
        @(negedge clk);
        check("drw1_pix", 32'(get8(5'd0, 6'd0)), 32'hFF);
        check("drw1_pix8", 32'(fb[11'd8]), 32'd0);
        check("drw1_ready", 32'(cmd_ready), 32'd1);

        // Repeat of the same draw erases and collides
        run(1'b0, 6'd0, 5'd0, 4'd1, 12'h200, lat);
        check("drw2_latency", 32'(lat), 32'd19);
        check("drw2_coll", 32'(collision), 32'd1);
        @(negedge clk);
        check("drw2_pix", 32'(get8(5'd0, 6'd0)), 32'h00);
        check("drw2_coll_hold", 32'(collision), 32'd1);

        // n = 0 clears collision and touches nothing
        run(1'b0, 6'd7, 5'd7, 4'd0, 12'h200, lat);
        check("n0_latency", 32'(lat), 32'd1);
        check("n0_coll", 32'(collision), 32'd0);
        check("n0_we", 32'(we_cnt - we0), 32'd0);
        check("n0_rd", 32'(rd_cnt - rd0), 32'd0);
        @(negedge clk);

        // Edge draw; sprite address also wraps past 0xFFF
        mem[12'hFFE] = 8'hF0; mem[12'hFFF] = 8'h0F; mem[12'h000] = 8'h81;
        run(1'b0, 6'd60, 5'd30, 4'd3, 12'hFFE, lat);
        check("edge_latency", 32'(lat), 32'd55);
        check("edge_coll", 32'(collision), 32'd0);
        check("edge_rd", 32'(rd_cnt - rd0), 32'd3);
        @(negedge clk);
        check("edge_row30", 32'(get8(5'd30, 6'd60)), 32'hF0);
`ifdef FB_DRAW_CLIP_EN
        check("edge_we", 32'(we_cnt - we0), 32'd4);
        check("edge_row31", 32'(get8(5'd31, 6'd60)), 32'h00);
        check("edge_row0", 32'(get8(5'd0, 6'd60)), 32'h00);
`else
        check("edge_we", 32'(we_cnt - we0), 32'd10);
        check("edge_row31", 32'(get8(5'd31, 6'd60)), 32'h0F);
        check("edge_row0", 32'(get8(5'd0, 6'd60)), 32'h81);
`endif

        // Command while busy is ignored
        we0 = we_cnt; rd0 = rd_cnt;
        start_cmd(1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
        repeat (10) @(negedge clk);
        cmd_op = 1'b0; cmd_n = 4'd1; cmd_valid = 1'b1;
        check("busy_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_ready2", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_done(14, 3000, lat);
        check("busy_cls_latency", 32'(lat), 32'd2049);
        check("busy_no_fetch", 32'(rd_cnt - rd0), 32'd0);
        @(negedge clk);
        check("busy_ready_after", 32'(cmd_ready), 32'd1);

        // Reset mid-CLS
        start_cmd(1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
        repeat (499) @(negedge clk);
        check("mid_cls_we", 32'(fb_WE), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        mem[12'h201] = 8'h3C;
        run(1'b0, 6'd5, 5'd3, 4'd2, 12'h200, lat);
        check("post_rst_latency", 32'(lat), 32'd37);
        check("post_rst_coll", 32'(collision), 32'd0);
        @(negedge clk);
        check("post_rst_row3", 32'(get8(5'd3, 6'd5)), 32'hFF);
        check("post_rst_row4", 32'(get8(5'd4, 6'd5)), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_fb_draw_ctrl.md
# chip8_fb_draw_ctrl

Sequencer that owns the general-purpose port of the CHIP-8 framebuffer and executes the two display opcodes, CLS (00E0) and DRW (DXYN). It accepts one command at a time from the CPU core and fetches sprite bytes from main memory. For every pixel it performs a read-modify-write (XOR) on the framebuffer and reports the VF collision flag. It sits between the CPU core, the main memory read port and the framebuffer's general port; the VGA port is untouched.

## Interface
- No parameters; geometry is fixed at 64x32.
- clk  in  1  system clock (same as framebuffer)
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = DRW, 1 = CLS
- cmd_x  in  6  sprite start column (Vx mod 64)
- cmd_y  in  5  sprite start row (Vy mod 32)
- cmd_n  in  4  sprite height in rows, 0..15
- cmd_i  in  12  sprite base address (I register)
- done  out  1  one-cycle pulse when a command completes
- collision  out  1  VF result; valid from the done cycle, held until the next accept
- mem_addr  out  12  sprite byte address
- mem_rd  out  1  read strobe; data returns one cycle later
- mem_data  in  8  sprite byte, valid the cycle after mem_rd
- fb_addr_x  out  6  framebuffer column
- fb_addr_y  out  5  framebuffer row
- fb_writedata  out  1  pixel to write
- fb_WE  out  1  framebuffer write enable
- fb_readdata  in  1  pixel read; valid one cycle after the address is presented

## Operation
- States: IDLE, CLR, FETCH, FWAIT, PRD, PWR, DONE.
- IDLE
  - cmd_ready = 1.
  - On accept, latch the command, clear collision, and reset row = 0 and bit = 0.
  - CLS goes to CLR.
  - DRW with n > 0 goes to FETCH.
  - DRW with n = 0 goes straight to DONE (collision 0).
- CLR
  - Linear 11-bit counter; addr_y = cnt[10:6], addr_x = cnt[5:0].
  - fb_writedata = 0, fb_WE = 1 every cycle.
  - After count 2047, go to DONE.
- FETCH: mem_addr = cmd_i + row (12-bit, wraps at 4095), mem_rd = 1; go to FWAIT.
- FWAIT: latch mem_data into the row byte; go to PRD.
- PRD
  - Present fb_addr_x = (x + bit) mod 64 and fb_addr_y = (y + row) mod 32, with fb_WE = 0.
  - Go to PWR.
- PWR
  - Keep the same address.
  - sbit = byte[7 - bit], MSB is leftmost.
  - fb_writedata = fb_readdata ^ sbit; fb_WE = sbit, so pixels with a 0 sprite bit are never written.
  - If fb_readdata && sbit, set collision (sticky).
  - If bit < 7: bit++, go to PRD.
  - Else, if row < n-1: row++, bit = 0, go to FETCH.
  - Else: go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- When idle: fb_WE = 0, mem_rd = 0, addresses = 0.
- Commands presented while busy are ignored; cmd_ready = 0 in every state except IDLE.

## Timing
- Reset values: state IDLE, cmd_ready 1, done 0, collision 0, mem_rd 0, mem_addr 0, fb_WE 0, fb_writedata 0, fb_addr_x 0, fb_addr_y 0.
- DRW latency from the accept edge to the done pulse: 18·n + 1 cycles (2 per row fetch, 16 per row of pixels, 1 for DONE). For n = 0 it is 1 cycle.
- CLS latency: 2048 + 1 cycles.
- Latency does not depend on data or on clipping.
- Reset asserted mid-command: immediate return to IDLE with all outputs at reset values. The framebuffer is left partially modified and nothing is rolled back.
- cmd_ready re-asserts in the cycle after done, so back-to-back commands are possible every latency+1 cycles.

## Configuration
- FB_DRAW_CLIP_EN defined:
  - A pixel with x + bit ≥ 64 (7-bit sum) or y + row ≥ 32 (6-bit sum) is clipped.
  - Clipped pixels: fb_WE = 0 in PWR and no collision contribution.
  - The cycles are still consumed.
- FB_DRAW_CLIP_EN undefined: coordinates wrap mod 64 / mod 32 (original CHIP-8 behaviour).

## Test plan
- **CLS after random fill:** → fb_WE high for exactly 2048 consecutive cycles covering addresses 0..2047; done 2049 cycles after accept; every pixel reads 0.
- **Single-row draw:** DRW x=0, y=0, n=1, I=0x200 with mem[0x200]=0xFF on a clear screen → pixels (0..7,0) = 1; collision 0; done at accept+19.
- **Repeat of the same draw:** → pixels (0..7,0) = 0; collision 1.
- **Edge draw:** DRW x=60, y=30, n=3 with bytes 0xF0,0x0F,0x81.
  - Wrap build: pixels appear at columns 60..63 and 0..3, rows 30, 31, 0.
  - FB_DRAW_CLIP_EN build: only the in-range pixels (60..63, rows 30..31) are written.
  - Both builds: done at accept+55.
- **n=0 and command while busy:** DRW n=0 → done at accept+1, collision 0, no fb_WE or mem_rd. A cmd_valid pulsed during a CLS is not accepted; cmd_ready stays 0.
- **Reset mid-command:** assert reset 500 cycles into CLS → all outputs return to reset values asynchronously. After release, cmd_ready = 1 and a new DRW completes normally.
